dual_lane_stream_source: RTL and testbench

Transmit-side driver for the two-lane ready/valid tuple interface (per lane: data, ready, valid) consumed by the delay-unit hierarchy. On a start command it emits a programmed number of beats per lane with deterministic payloads and programmable inter-beat gaps. It obeys the valid/ready protocol rules and flags any lane whose valid waits too long for ready. It sits in front of DelayUnit in traffic-generation and bring-up harnesses.

---
 rtl/dual_lane_stream_pkg.sv | 20 ++
 rtl/dual_lane_stream_source_lane.sv | 87 ++++++++
 rtl/dual_lane_stream_source.sv | 105 ++++++++++
 tb/tb_dual_lane_stream_source.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_lane_stream_pkg.sv
// Shared types and constants for the two-lane ready/valid stream source.
package dual_lane_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane 1 payloads start half-way round the payload space so the lanes stay distinguishable.
  function automatic int unsigned lane1_offset(input int unsigned data_width);
    return 32'd1 << (data_width - 1);
  endfunction

  // The stall counter must be able to reach STALL_LIMIT+1.
  function automatic int unsigned stall_cnt_width(input int unsigned stall_limit);
    return $clog2(stall_limit + 2);
  endfunction

endpackage

// File: rtl/dual_lane_stream_source_lane.sv
// One lane of the stream source: beat counter, payload, inter-beat gap, stall watch.
module stream_lane_gen
  import dual_lane_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 5,
  parameter int COUNT_WIDTH = 8,
  parameter int STALL_LIMIT = 3,
  parameter logic [DATA_WIDTH-1:0] PAYLOAD_OFFSET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   run,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [1:0]             gap,
  input  logic                   ready,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   valid,
  output logic                   last,
  output logic                   stall_hit
);

  localparam int unsigned SW = stall_cnt_width(STALL_LIMIT);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_EDGE = SW'(STALL_LIMIT);

  logic [COUNT_WIDTH-1:0] remaining, remaining_n;
  logic [DATA_WIDTH-1:0]  data_n;
  logic [1:0]             gap_cnt, gap_n;
  logic [SW-1:0]          stall_cnt, stall_n;
  logic                   valid_n;
  logic                   hs;
  logic                   stalled;

  assign hs      = valid & ready;
  assign stalled = valid & ~ready;

  always_comb begin
    remaining_n = remaining;
    data_n      = data;
    gap_n       = gap_cnt;
    stall_n     = stall_cnt;
    valid_n     = valid;
    if (load) begin
      remaining_n = count;
      data_n      = seed + PAYLOAD_OFFSET;
      gap_n       = 2'd0;
      stall_n     = '0;
      valid_n     = (count != '0);
    end else if (run) begin
      if (hs) begin
        remaining_n = remaining - COUNT_WIDTH'(1);
        data_n      = data + DATA_WIDTH'(1);
        gap_n       = gap;
      end else if (gap_cnt != 2'd0) begin
        gap_n = gap_cnt - 2'd1;
      end
      valid_n = (remaining_n != '0) && (gap_n == 2'd0);
      // Saturate so a long stall cannot wrap back below the limit.
      if (stalled)
        stall_n = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + SW'(1);
      else
        stall_n = '0;
    end
  end

  assign last      = (remaining_n == '0);
  assign stall_hit = run && stalled && (stall_cnt == STALL_EDGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      data      <= '0;
      gap_cnt   <= 2'd0;
      stall_cnt <= '0;
      valid     <= 1'b0;
    end else begin
      remaining <= remaining_n;
      data      <= data_n;
      gap_cnt   <= gap_n;
      stall_cnt <= stall_n;
      valid     <= valid_n;
    end
  end

endmodule

// File: rtl/dual_lane_stream_source.sv
// Two-lane ready/valid traffic source: command FSM, gap capture, done pulse, sticky stall flag.
module dual_lane_stream_source
  import dual_lane_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 5,
  parameter int COUNT_WIDTH = 8,
  parameter int STALL_LIMIT = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [1:0]             gap,
  output logic [DATA_WIDTH-1:0]  O_0_data,
  input  logic                   O_0_ready,
  output logic                   O_0_valid,
  output logic [DATA_WIDTH-1:0]  O_1_data,
  input  logic                   O_1_ready,
  output logic                   O_1_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   stall_err
);

  localparam logic [DATA_WIDTH-1:0] LANE1_OFFSET = DATA_WIDTH'(lane1_offset(DATA_WIDTH));

  state_t     state, state_n;
  logic [1:0] gap_q;
  logic       accept;
  logic       run;
  logic       last0, last1;
  logic       hit0, hit1;

  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  stream_lane_gen #(
    .DATA_WIDTH    (DATA_WIDTH),
    .COUNT_WIDTH   (COUNT_WIDTH),
    .STALL_LIMIT   (STALL_LIMIT),
    .PAYLOAD_OFFSET('0)
  ) u_lane0 (
    .clk      (CLK),
    .rst      (RESET),
    .load     (accept),
    .run      (run),
    .count    (count),
    .seed     (seed),
    .gap      (gap_q),
    .ready    (O_0_ready),
    .data     (O_0_data),
    .valid    (O_0_valid),
    .last     (last0),
    .stall_hit(hit0)
  );

  stream_lane_gen #(
    .DATA_WIDTH    (DATA_WIDTH),
    .COUNT_WIDTH   (COUNT_WIDTH),
    .STALL_LIMIT   (STALL_LIMIT),
    .PAYLOAD_OFFSET(LANE1_OFFSET)
  ) u_lane1 (
    .clk      (CLK),
    .rst      (RESET),
    .load     (accept),
    .run      (run),
    .count    (count),
    .seed     (seed),
    .gap      (gap_q),
    .ready    (O_1_ready),
    .data     (O_1_data),
    .valid    (O_1_valid),
    .last     (last1),
    .stall_hit(hit1)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (count != '0) ? RUN : DONE;
      // last already accounts for a final handshake happening this cycle.
      RUN:  if (last0 && last1) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      gap_q     <= 2'd0;
      stall_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) gap_q <= gap;
      // A new stall outranks the clear from an accepted start.
      if (hit0 || hit1) stall_err <= 1'b1;
      else if (accept)  stall_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_lane_stream_source.sv
// Scoreboard bench for dual_lane_stream_source: expected beats queued at start, checked at handshake.
module tb_dual_lane_stream_source;

  localparam int DW    = 5;
  localparam int CW    = 8;
  localparam int LIMIT = 3;
  localparam int MODV  = 1 << DW;
  localparam int HALF  = 1 << (DW - 1);

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [DW-1:0] seed = '0;
  logic [1:0]    gap = 2'd0;
  logic [DW-1:0] O_0_data, O_1_data;
  logic          O_0_ready = 1'b1, O_1_ready = 1'b1;
  logic          O_0_valid, O_1_valid;
  logic          busy, done, stall_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int exp0[$];
  int exp1[$];
  int hs_t0[$];
  int hs_t1[$];

  logic          held0 = 1'b0, held1 = 1'b0;
  logic [DW-1:0] held_data0, held_data1;
  int            e0, e1;

  dual_lane_stream_source #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .STALL_LIMIT(LIMIT)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .count    (count),
    .seed     (seed),
    .gap      (gap),
    .O_0_data (O_0_data),
    .O_0_ready(O_0_ready),
    .O_0_valid(O_0_valid),
    .O_1_data (O_1_data),
    .O_1_ready(O_1_ready),
    .O_1_valid(O_1_valid),
    .busy     (busy),
    .done     (done),
    .stall_err(stall_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Handshake monitor: scoreboard pops plus hold-while-stalled protocol checks.
  always @(negedge CLK) begin
    if (RESET) begin
      held0 = 1'b0;
      held1 = 1'b0;
    end else begin
      if (held0) begin
        checks++;
        if (O_0_valid !== 1'b1 || O_0_data !== held_data0) begin
          errors++;
          $display("FAIL lane0_hold: valid=%0b data=%0d required valid=1 data=%0d", O_0_valid, O_0_data, held_data0);
        end
      end
      if (held1) begin
        checks++;
        if (O_1_valid !== 1'b1 || O_1_data !== held_data1) begin
          errors++;
          $display("FAIL lane1_hold: valid=%0b data=%0d required valid=1 data=%0d", O_1_valid, O_1_data, held_data1);
        end
      end
      if (O_0_valid === 1'b1 && O_0_ready === 1'b1) begin
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL lane0_extra_beat: data=%0d required no beat", O_0_data);
        end else begin
          e0 = exp0.pop_front();
          if (O_0_data !== DW'(e0)) begin
            errors++;
            $display("FAIL lane0_data: got %0d required %0d", O_0_data, e0);
          end
        end
        hs_t0.push_back(cyc);
      end
      if (O_1_valid === 1'b1 && O_1_ready === 1'b1) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL lane1_extra_beat: data=%0d required no beat", O_1_data);
        end else begin
          e1 = exp1.pop_front();
          if (O_1_data !== DW'(e1)) begin
            errors++;
            $display("FAIL lane1_data: got %0d required %0d", O_1_data, e1);
          end
        end
        hs_t1.push_back(cyc);
      end
      held0      = (O_0_valid === 1'b1) && (O_0_ready === 1'b0);
      held1      = (O_1_valid === 1'b1) && (O_1_ready === 1'b0);
      held_data0 = O_0_data;
      held_data1 = O_1_data;
    end
  end

  // Issue a start command and queue the beats it must produce; returns the accept cycle.
  task automatic issue(input int c, input int s, input int g, output int acc);
    @(posedge CLK); #1;
    start = 1'b1;
    count = CW'(c);
    seed  = DW'(s);
    gap   = 2'(g);
    acc   = cyc + 1;
    hs_t0.delete();
    hs_t1.delete();
    for (int i = 0; i < c; i++) begin
      exp0.push_back((s + i) % MODV);
      exp1.push_back((s + HALF + i) % MODV);
    end
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int ndone, output int done_at,
                           output int nbusy, output int nvalid);
    ndone = 0; done_at = -1; nbusy = 0; nvalid = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (done === 1'b1) begin ndone++; done_at = cyc; end
      if (busy === 1'b1) nbusy++;
      if (O_0_valid === 1'b1 || O_1_valid === 1'b1) nvalid++;
      if (busy !== 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: busy still %0b after %0d cycles required 0", busy, budget);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({O_0_valid, O_1_valid, busy, done, stall_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: v0 v1 busy done err=%b required 00000", {O_0_valid, O_1_valid, busy, done, stall_err});
    end
    checks++;
    if (O_0_data !== '0 || O_1_data !== '0) begin
      errors++;
      $display("FAIL reset_data: d0=%0d d1=%0d required 0 0", O_0_data, O_1_data);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_basic;
    int acc, nd, dat, nb, nv, f0, l0;
    issue(4, 3, 0, acc);
    wait_idle(30, nd, dat, nb, nv);
    f0 = (hs_t0.size() > 0) ? hs_t0[0] : -1;
    l0 = (hs_t0.size() > 0) ? hs_t0[hs_t0.size()-1] : -1;
    checks++;
    if (hs_t0.size() != 4 || f0 != acc || l0 != acc + 3) begin
      errors++;
      $display("FAIL basic_lane0_timing: beats=%0d first=%0d last=%0d required 4 %0d %0d", hs_t0.size(), f0, l0, acc, acc + 3);
    end
    checks++;
    if (hs_t1.size() != 4) begin
      errors++;
      $display("FAIL basic_lane1_beats: got %0d required 4", hs_t1.size());
    end
    checks++;
    if (nd != 1 || dat != acc + 4) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d at=%0d required 1 at %0d", nd, dat, acc + 4);
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL basic_lost_beats: left %0d %0d required 0 0", exp0.size(), exp1.size());
    end
    checks++;
    if (stall_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_stall_err: got %0b required 0", stall_err);
    end
  endtask

  task automatic test_backpressure(input int n);
    int acc, nd, dat, nb, nv, l1;
    logic exp_err;
    exp_err = (n > LIMIT);
    issue(4, 3, 0, acc);
    @(posedge CLK); #1;
    O_0_ready = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
    O_0_ready = 1'b1;
    wait_idle(40, nd, dat, nb, nv);
    l1 = (hs_t1.size() > 0) ? hs_t1[hs_t1.size()-1] : -1;
    checks++;
    if (nd != 1 || dat != acc + 4 + n) begin
      errors++;
      $display("FAIL bp%0d_done: pulses=%0d at=%0d required 1 at %0d", n, nd, dat, acc + 4 + n);
    end
    checks++;
    if (hs_t0.size() != 4 || hs_t1.size() != 4 || l1 != acc + 3) begin
      errors++;
      $display("FAIL bp%0d_beats: l0=%0d l1=%0d l1_last=%0d required 4 4 %0d", n, hs_t0.size(), hs_t1.size(), l1, acc + 3);
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL bp%0d_lost_beats: left %0d %0d required 0 0", n, exp0.size(), exp1.size());
    end
    @(negedge CLK);
    checks++;
    if (stall_err !== exp_err) begin
      errors++;
      $display("FAIL bp%0d_stall_err: got %0b required %0b", n, stall_err, exp_err);
    end
  endtask

  task automatic test_gap_wrap;
    int acc, nd, dat, nb, nv;
    int t0 [3];
    int t1 [3];
    issue(3, 30, 2, acc);
    @(negedge CLK);
    checks++;
    if (stall_err !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_stall_err: got %0b required 0", stall_err);
    end
    wait_idle(40, nd, dat, nb, nv);
    for (int i = 0; i < 3; i++) begin
      t0[i] = (hs_t0.size() > i) ? hs_t0[i] : -1;
      t1[i] = (hs_t1.size() > i) ? hs_t1[i] : -1;
    end
    checks++;
    if (hs_t0.size() != 3 || t0[0] != acc || t0[1] != acc + 3 || t0[2] != acc + 6) begin
      errors++;
      $display("FAIL gap_lane0_timing: t=%0d,%0d,%0d required %0d,%0d,%0d", t0[0], t0[1], t0[2], acc, acc + 3, acc + 6);
    end
    checks++;
    if (hs_t1.size() != 3 || t1[0] != acc || t1[1] != acc + 3 || t1[2] != acc + 6) begin
      errors++;
      $display("FAIL gap_lane1_timing: t=%0d,%0d,%0d required %0d,%0d,%0d", t1[0], t1[1], t1[2], acc, acc + 3, acc + 6);
    end
    checks++;
    if (nd != 1 || dat != acc + 7 || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL gap_done: pulses=%0d at=%0d left=%0d,%0d required 1 at %0d left 0,0", nd, dat, exp0.size(), exp1.size(), acc + 7);
    end
  endtask

  task automatic test_zero_count;
    int acc, nd, dat, nb, nv;
    issue(0, 5, 1, acc);
    wait_idle(10, nd, dat, nb, nv);
    checks++;
    if (nd != 1 || dat != acc) begin
      errors++;
      $display("FAIL zero_done: pulses=%0d at=%0d required 1 at %0d", nd, dat, acc);
    end
    checks++;
    if (nb != 1) begin
      errors++;
      $display("FAIL zero_busy: busy cycles=%0d required 1", nb);
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL zero_valid: valid cycles=%0d required 0", nv);
    end
  endtask

  task automatic test_ignored_start_reset;
    int acc, nd, dat, nb, nv, nd2;
    issue(8, 5, 0, acc);
    start = 1'b1;
    count = CW'(2);
    seed  = DW'(9);
    O_1_ready = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    O_0_ready = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (stall_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_err: got %0b required 1", stall_err);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    O_0_ready = 1'b1;
    O_1_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({O_0_valid, O_1_valid, busy, done, stall_err} !== 5'b0 || O_0_data !== '0) begin
      errors++;
      $display("FAIL abort_state: v0 v1 busy done err=%b d0=%0d required 00000 d0=0", {O_0_valid, O_1_valid, busy, done, stall_err}, O_0_data);
    end
    checks++;
    if (exp0.size() != 5 || exp1.size() != 8) begin
      errors++;
      $display("FAIL abort_beats: remaining %0d %0d required 5 8", exp0.size(), exp1.size());
    end
    exp0.delete();
    exp1.delete();
    nd2 = 0;
    repeat (6) begin
      @(negedge CLK);
      if (done === 1'b1 || busy === 1'b1) nd2++;
    end
    checks++;
    if (nd2 != 0) begin
      errors++;
      $display("FAIL abort_no_done: done/busy cycles=%0d required 0", nd2);
    end
    issue(2, 7, 0, acc);
    wait_idle(20, nd, dat, nb, nv);
    checks++;
    if (nd != 1 || dat != acc + 2 || hs_t0.size() != 2 || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL replay: pulses=%0d at=%0d beats=%0d left=%0d,%0d required 1 at %0d beats 2 left 0,0", nd, dat, hs_t0.size(), exp0.size(), exp1.size(), acc + 2);
    end
    checks++;
    if (stall_err !== 1'b0) begin
      errors++;
      $display("FAIL replay_stall_err: got %0b required 0", stall_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure(2);
    test_backpressure(4);
    test_gap_wrap();
    test_zero_count();
    test_ignored_start_reset();
    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
